// File: rtl/meikyuu_pkg.sv
// Shared types and constants for the maze game: exit directions, game-flow
// states, VGA frame geometry and the default room-grid size.
package meikyuu_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_TRANS = 2'd2,
    ST_WIN   = 2'd3
  } state_e;

  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int MAP_W_DEF = 8;
  localparam int MAP_H_DEF = 8;

  localparam logic [9:0] SEC_MAX   = 10'd999;
  localparam logic [7:0] ROOMS_MAX = 8'd255;

  // The player re-enters a new room through the side facing the one it left.
  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return dir + 2'd2;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Room-exit handshake between the player block (master) and the game
// controller (slave), including the respawn notification back to the player.
interface game_controller_if;
  logic       exit_valid;
  logic [1:0] exit_dir;
  logic       exit_ack;
  logic       exit_ok;
  logic       respawn;
  logic [1:0] respawn_side;

  modport master (
    output exit_valid, exit_dir,
    input  exit_ack, exit_ok, respawn, respawn_side
  );

  modport slave (
    input  exit_valid, exit_dir,
    output exit_ack, exit_ok, respawn, respawn_side
  );
endinterface

// File: rtl/game_controller_frame_timer.sv
// Frame tick from the VGA counters plus an elapsed-seconds counter that only
// advances while the game flow enables it.
module frame_timer
  import meikyuu_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] h_cnt_i,
  input  logic [9:0] v_cnt_i,
  input  logic       run_i,
  output logic       frame_tick_o,
  output logic [9:0] seconds_o
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  logic          tick_q;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]    seconds_q, seconds_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    seconds_d   = seconds_q;
    if (tick_q && run_i) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        if (seconds_q != SEC_MAX) seconds_d = seconds_q + 10'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q      <= 1'b0;
      frame_cnt_q <= '0;
      seconds_q   <= '0;
    end else begin
      tick_q      <= (h_cnt_i == 10'd0) && (v_cnt_i == 10'd0);
      frame_cnt_q <= frame_cnt_d;
      seconds_q   <= seconds_d;
    end
  end

  assign frame_tick_o = tick_q;
  assign seconds_o    = seconds_q;

endmodule

// File: rtl/game_controller.sv
// Maze game-flow sequencer: owns the current room, arbitrates room exits
// against the grid edges and sequences title / play / transition / win.
module game_controller
  import meikyuu_pkg::*;
#(
  parameter int MAP_W          = MAP_W_DEF,
  parameter int MAP_H          = MAP_H_DEF,
  parameter int START_X        = 0,
  parameter int START_Y        = 0,
  parameter int TRANS_FRAMES   = 4,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  input  logic [9:0]        h_counter,
  input  logic [9:0]        v_counter,
  input  logic              btn_start,
  input  logic              house_hit,
  game_controller_if.slave  exit_bus,
  output logic [2:0]        mapa_x_pos,
  output logic [2:0]        mapa_y_pos,
  output logic              player_enable,
  output logic              end_game,
  output logic              frame_tick,
  output logic [9:0]        seconds,
  output logic [7:0]        rooms_entered
);

  localparam logic signed [4:0] MAP_W_S    = 5'(MAP_W);
  localparam logic signed [4:0] MAP_H_S    = 5'(MAP_H);
  localparam logic [3:0]        TRANS_LAST = 4'(TRANS_FRAMES - 1);

  state_e      state_q;
  logic [2:0]  x_q, y_q;
  logic        armed_q;
  logic [3:0]  trans_cnt_q;
  logic        exit_ack_q, exit_ok_q, respawn_q;
  logic [1:0]  respawn_side_q;
  logic        player_enable_q, end_game_q;
  logic [7:0]  rooms_q;

  logic signed [4:0] tgt_x, tgt_y;
  logic              in_grid;

  frame_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_frame_timer (
    .clk_i        (CLOCK_25),
    .rst_i        (reset),
    .h_cnt_i      (h_counter),
    .v_cnt_i      (v_counter),
    .run_i        ((state_q == ST_PLAY) || (state_q == ST_TRANS)),
    .frame_tick_o (frame_tick),
    .seconds_o    (seconds)
  );

  // Signed target lets a step off row/column 0 show up as -1.
  always_comb begin
    tgt_x = $signed({2'b00, x_q});
    tgt_y = $signed({2'b00, y_q});
    case (exit_bus.exit_dir)
      DIR_UP:    tgt_y = tgt_y - 5'sd1;
      DIR_RIGHT: tgt_x = tgt_x + 5'sd1;
      DIR_DOWN:  tgt_y = tgt_y + 5'sd1;
      DIR_LEFT:  tgt_x = tgt_x - 5'sd1;
    endcase
    in_grid = (tgt_x >= 5'sd0) && (tgt_x < MAP_W_S) &&
              (tgt_y >= 5'sd0) && (tgt_y < MAP_H_S);
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      x_q             <= 3'(START_X);
      y_q             <= 3'(START_Y);
      armed_q         <= 1'b1;
      trans_cnt_q     <= '0;
      exit_ack_q      <= 1'b0;
      exit_ok_q       <= 1'b0;
      respawn_q       <= 1'b0;
      respawn_side_q  <= '0;
      player_enable_q <= 1'b0;
      end_game_q      <= 1'b0;
      rooms_q         <= '0;
    end else begin
      exit_ack_q <= 1'b0;
      respawn_q  <= 1'b0;
      // A held request is answered once; it must drop before the next one counts.
      if (!exit_bus.exit_valid) armed_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (btn_start) begin
            state_q         <= ST_PLAY;
            player_enable_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (house_hit) begin
            state_q         <= ST_WIN;
            player_enable_q <= 1'b0;
            end_game_q      <= 1'b1;
          end else if (exit_bus.exit_valid && armed_q) begin
            armed_q    <= 1'b0;
            exit_ack_q <= 1'b1;
            exit_ok_q  <= in_grid;
            if (in_grid) begin
              x_q             <= tgt_x[2:0];
              y_q             <= tgt_y[2:0];
              respawn_q       <= 1'b1;
              respawn_side_q  <= opposite_dir(exit_bus.exit_dir);
              if (rooms_q != ROOMS_MAX) rooms_q <= rooms_q + 8'd1;
              trans_cnt_q     <= '0;
              state_q         <= ST_TRANS;
              player_enable_q <= 1'b0;
            end
          end
        end
        ST_TRANS: begin
          if (frame_tick) begin
            if (trans_cnt_q == TRANS_LAST) begin
              trans_cnt_q     <= '0;
              state_q         <= ST_PLAY;
              player_enable_q <= 1'b1;
            end else begin
              trans_cnt_q <= trans_cnt_q + 4'd1;
            end
          end
        end
        ST_WIN: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exit_bus.exit_ack     = exit_ack_q;
  assign exit_bus.exit_ok      = exit_ok_q;
  assign exit_bus.respawn      = respawn_q;
  assign exit_bus.respawn_side = respawn_side_q;
  assign mapa_x_pos            = x_q;
  assign mapa_y_pos            = y_q;
  assign player_enable         = player_enable_q;
  assign end_game              = end_game_q;
  assign rooms_entered         = rooms_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: table of room moves, randomized walk against a
// room/timer model, plus hand sequences for saturation, reset-in-TRANS and win.
module tb_game_controller;

  localparam int TF  = 4;
  localparam int FPS = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h, v;
  logic       btn, hh;
  logic [2:0] xo, yo;
  logic       pen, eg, ft;
  logic [9:0] sec;
  logic [7:0] rooms;

  game_controller_if bus();

  game_controller #(
    .MAP_W(8), .MAP_H(8), .START_X(0), .START_Y(0),
    .TRANS_FRAMES(TF), .FRAMES_PER_SEC(FPS)
  ) dut (
    .CLOCK_25      (clk),
    .reset         (rst),
    .h_counter     (h),
    .v_counter     (v),
    .btn_start     (btn),
    .house_hit     (hh),
    .exit_bus      (bus),
    .mapa_x_pos    (xo),
    .mapa_y_pos    (yo),
    .player_enable (pen),
    .end_game      (eg),
    .frame_tick    (ft),
    .seconds       (sec),
    .rooms_entered (rooms)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int m_ticks  = 0;   // frame ticks seen while the game runs since last reset
  int m_rooms  = 0;   // accepted moves since last reset

  typedef struct {
    logic [1:0] dir;
    bit         ok;
    int         x;
    int         y;
  } mv_t;

  mv_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    h = 10'd0; v = 10'd0;
    cyc();
    h = 10'd5; v = 10'd7;
    cyc();
  endtask

  task automatic fast_ticks(input int n);
    h = 10'd0; v = 10'd0;
    repeat (n) cyc();
    h = 10'd5; v = 10'd7;
    cyc();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_ticks = 0;
    m_rooms = 0;
  endtask

  task automatic start_game();
    btn = 1'b1;
    cyc();
    btn = 1'b0;
    chk("start.enable", pen, 1);
  endtask

  function automatic int exp_seconds();
    return (m_ticks / FPS > 999) ? 999 : m_ticks / FPS;
  endfunction

  task automatic do_exit(input logic [1:0] dir, input bit ok, input int ex, input int ey,
                         input string tag);
    bus.exit_dir   = dir;
    bus.exit_valid = 1'b1;
    cyc();
    chk({tag, ".ack"}, bus.exit_ack, 1);
    chk({tag, ".ok"}, bus.exit_ok, ok);
    chk({tag, ".x"}, xo, ex);
    chk({tag, ".y"}, yo, ey);
    chk({tag, ".respawn"}, bus.respawn, ok);
    if (ok) begin
      chk({tag, ".side"}, bus.respawn_side, (int'(dir) + 2) % 4);
      if (m_rooms < 255) m_rooms++;
    end
    chk({tag, ".enable"}, pen, ok ? 0 : 1);
    chk({tag, ".rooms"}, rooms, m_rooms);
    bus.exit_valid = 1'b0;
    cyc();
    chk({tag, ".ack_pulse"}, bus.exit_ack, 0);
    chk({tag, ".respawn_pulse"}, bus.respawn, 0);
    if (ok) begin
      for (int k = 1; k <= TF; k++) begin
        frame();
        m_ticks++;
        chk({tag, ".trans_enable"}, pen, (k == TF) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int  rx, ry, tx, ty, d, nf;
    bit  ok, seen, acked, lost;

    rst = 1'b1; btn = 1'b0; hh = 1'b0;
    h = 10'd5; v = 10'd7;
    bus.exit_valid = 1'b0; bus.exit_dir = 2'd0;

    tbl[0] = '{2'd1, 1'b1, 1, 0};
    tbl[1] = '{2'd0, 1'b0, 1, 0};
    tbl[2] = '{2'd3, 1'b1, 0, 0};
    tbl[3] = '{2'd3, 1'b0, 0, 0};
    tbl[4] = '{2'd2, 1'b1, 0, 1};
    tbl[5] = '{2'd0, 1'b1, 0, 0};

    // Reset values
    cyc(); cyc();
    rst = 1'b0;
    chk("rst.x", xo, 0);
    chk("rst.y", yo, 0);
    chk("rst.enable", pen, 0);
    chk("rst.end_game", eg, 0);
    chk("rst.ack", bus.exit_ack, 0);
    chk("rst.ok", bus.exit_ok, 0);
    chk("rst.respawn", bus.respawn, 0);
    chk("rst.side", bus.respawn_side, 0);
    chk("rst.tick", ft, 0);
    chk("rst.seconds", sec, 0);
    chk("rst.rooms", rooms, 0);

    // frame_tick decode and pulse width; ticks in IDLE do not count time
    h = 10'd0; v = 10'd3; cyc();
    chk("tick.h0_only", ft, 0);
    h = 10'd3; v = 10'd0; cyc();
    chk("tick.v0_only", ft, 0);
    h = 10'd0; v = 10'd0; cyc();
    chk("tick.origin", ft, 1);
    h = 10'd5; v = 10'd7; cyc();
    chk("tick.pulse", ft, 0);
    fast_ticks(120);
    chk("idle.seconds", sec, 0);
    chk("idle.enable", pen, 0);

    start_game();
    chk("start.x", xo, 0);
    chk("start.y", yo, 0);

    for (int i = 0; i < 6; i++)
      do_exit(tbl[i].dir, tbl[i].ok, tbl[i].x, tbl[i].y, $sformatf("tbl%0d", i));

    // Walk to the far corner, then both outward directions must be rejected
    for (int i = 1; i <= 7; i++) do_exit(2'd1, 1'b1, i, 0, "walk_r");
    for (int i = 1; i <= 7; i++) do_exit(2'd2, 1'b1, 7, i, "walk_d");
    do_exit(2'd1, 1'b0, 7, 7, "corner.right");
    do_exit(2'd2, 1'b0, 7, 7, "corner.down");
    chk("corner.seconds", sec, exp_seconds());

    // Random walk against a coordinate model
    rx = 7; ry = 7;
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 3));
      tx = rx + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
      ty = ry + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
      ok = (tx >= 0) && (tx < 8) && (ty >= 0) && (ty < 8);
      if (ok) begin rx = tx; ry = ty; end
      do_exit(2'(d), ok, rx, ry, "rand");
      nf = int'($urandom_range(0, 2));
      for (int k = 0; k < nf; k++) begin frame(); m_ticks++; end
      chk("rand.seconds", sec, exp_seconds());
    end

    // Enough accepted moves to saturate rooms_entered
    for (int i = 0; i < 260; i++) begin
      d = (rx < 7) ? 1 : 3;
      rx = rx + ((d == 1) ? 1 : -1);
      do_exit(2'(d), 1'b1, rx, ry, "bounce");
    end
    chk("rooms.saturated", rooms, 255);

    // Seconds: exact count, then saturation
    reset_dut();
    chk("sec.reset", sec, 0);
    start_game();
    fast_ticks(60 * 61);
    m_ticks += 60 * 61;
    chk("sec.61", sec, 61);
    fast_ticks(57000);
    m_ticks += 57000;
    chk("sec.saturate", sec, 999);
    chk("sec.model", sec, exp_seconds());

    // Reset two frames into a transition; house_hit ignored in TRANS
    reset_dut();
    start_game();
    bus.exit_dir = 2'd1; bus.exit_valid = 1'b1;
    cyc();
    chk("midtrans.respawn", bus.respawn, 1);
    bus.exit_valid = 1'b0;
    hh = 1'b1;
    frame(); frame();
    chk("midtrans.no_win", eg, 0);
    chk("midtrans.enable", pen, 0);
    hh = 1'b0;
    reset_dut();
    chk("midtrans.rst_enable", pen, 0);
    chk("midtrans.rst_x", xo, 0);
    chk("midtrans.rst_y", yo, 0);
    chk("midtrans.rst_rooms", rooms, 0);
    chk("midtrans.rst_respawn", bus.respawn, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      h = (i % 2 == 0) ? 10'd0 : 10'd5;
      v = (i % 2 == 0) ? 10'd0 : 10'd7;
      cyc();
      if (bus.respawn || pen) seen = 1'b1;
    end
    h = 10'd5; v = 10'd7;
    chk("midtrans.idle_quiet", seen, 0);
    start_game();
    lost = 1'b0;
    for (int i = 0; i < TF; i++) begin
      frame(); m_ticks++;
      if (!pen) lost = 1'b1;
    end
    chk("midtrans.count_discarded", lost, 0);

    // Win beats a simultaneous exit request and holds
    hh = 1'b1;
    bus.exit_dir = 2'd1; bus.exit_valid = 1'b1;
    cyc();
    chk("win.end_game", eg, 1);
    chk("win.enable", pen, 0);
    chk("win.no_ack", bus.exit_ack, 0);
    chk("win.x", xo, 0);
    chk("win.y", yo, 0);
    hh = 1'b0;
    acked = 1'b0; lost = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      h = (i % 2 == 0) ? 10'd0 : 10'd5;
      v = (i % 2 == 0) ? 10'd0 : 10'd7;
      cyc();
      if (bus.exit_ack) acked = 1'b1;
      if (!eg || pen) lost = 1'b1;
    end
    h = 10'd5; v = 10'd7;
    bus.exit_valid = 1'b0;
    chk("win.never_acked", acked, 0);
    chk("win.held", lost, 0);
    chk("win.x_hold", xo, 0);
    chk("win.seconds_frozen", sec, exp_seconds());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Game-flow sequencer for the maze. It owns the current room coordinates on the 8x8 room grid and arbitrates the player's room-exit requests against the grid bounds. It also sequences the title / play / room-transition / win phases and keeps elapsed-time and rooms-entered counters. It sits between the VGA counter logic, the player block and the tile/collision lookup, and replaces ad-hoc end-game latching.

## Interface
Parameters:
- MAP_W, 8, rooms per row
- MAP_H, 8, rooms per column
- START_X, 0, initial room column
- START_Y, 0, initial room row
- TRANS_FRAMES, 4, frames the player is frozen after a room change (1..15)
- FRAMES_PER_SEC, 60, frame ticks per elapsed second

Ports:
- CLOCK_25  in  1  pixel clock; only clock
- reset  in  1  synchronous, active-high
- h_counter  in  10  VGA horizontal counter (0..799)
- v_counter  in  10  VGA vertical counter (0..524)
- btn_start  in  1  start request, active-high level
- exit_valid  in  1  player requests leaving the room; held until exit_ack
- exit_dir  in  2  0 up, 1 right, 2 down, 3 left; stable while exit_valid
- house_hit  in  1  player overlaps the objective
- exit_ack  out  1  one-cycle acknowledge of exit request
- exit_ok  out  1  valid with exit_ack: 1 = move accepted, 0 = rejected (grid edge)
- respawn  out  1  one-cycle pulse: player must reposition
- respawn_side  out  2  side the player enters from (opposite of exit_dir)
- mapa_x_pos  out  3  current room column
- mapa_y_pos  out  3  current room row
- player_enable  out  1  player may move
- end_game  out  1  win latched
- frame_tick  out  1  one-cycle pulse per frame
- seconds  out  10  elapsed seconds, saturating at 999
- rooms_entered  out  8  accepted moves, saturating at 255

## Operation
- States: IDLE, PLAY, TRANS, WIN.
- IDLE: player_enable=0. btn_start=1 → PLAY next cycle.
- PLAY: player_enable=1.
  - house_hit=1 → WIN. It has priority over a simultaneous exit_valid, which is neither acked nor acted on.
  - Otherwise, exit_valid=1 is sampled and answered the next cycle with exit_ack=1.
  - Target room: up y−1, down y+1, left x−1, right x+1.
  - Target inside 0..MAP_W−1 / 0..MAP_H−1: exit_ok=1; coordinates update in the same cycle as the ack; respawn=1 with respawn_side=(exit_dir+2) mod 4; rooms_entered+1; → TRANS.
  - Target outside the grid: exit_ok=0, coordinates unchanged, stay in PLAY.
  - After an ack, a new request is not sampled until exit_valid has been low for at least one cycle.
- TRANS: player_enable=0. Counts frame_ticks; on the TRANS_FRAMES-th tick → PLAY. house_hit is ignored.
- WIN: end_game=1, player_enable=0. Held until reset. Exit requests are never acked.
- frame_tick: registered pulse, asserted the cycle after h_counter==0 && v_counter==0.
- seconds: a frame counter runs in PLAY and TRANS only. Every FRAMES_PER_SEC ticks it wraps to 0 and seconds increments. It freezes in IDLE and WIN.

## Timing
- Reset values (all outputs registered):
  - state=IDLE
  - mapa_x_pos=START_X, mapa_y_pos=START_Y
  - player_enable=0, end_game=0
  - exit_ack=0, exit_ok=0
  - respawn=0, respawn_side=0
  - frame_tick=0, seconds=0, rooms_entered=0
  - internal frame/transition counters=0
- Exit latency: 1 cycle from the first exit_valid sample in PLAY to exit_ack.
- Win latency: 1 cycle from house_hit in PLAY to end_game=1 and player_enable=0.
- Reset asserted in any state restores every value above on the next edge. This includes mid-TRANS, where the pending transition count is discarded.
- Counter saturation: seconds holds at 999; rooms_entered holds at 255.
- Corner rooms: each out-of-grid direction is rejected independently.

## Structure
- Shared package meikyuu_pkg:
  - direction encoding (UP/RIGHT/DOWN/LEFT)
  - state encoding
  - H_TOTAL=800, V_TOTAL=525
  - MAP_W/MAP_H defaults
- Sub-module frame_timer: frame_tick generation, per-second divider and saturating seconds counter, with a run enable from the FSM.
- FSM, exit arbitration and coordinate registers stay in game_controller.

## Test plan
- Reset, then btn_start=1 → PLAY next cycle; player_enable=1; room (0,0).
- In (0,0): exit_valid, dir=1 → exit_ack=1, exit_ok=1, room (1,0), respawn=1, respawn_side=3. player_enable=0 for exactly 4 frame_ticks, then back to 1.
- In (0,0): dir=0 → exit_ack=1, exit_ok=0, room unchanged, no respawn. Repeat at (7,7) with dir=1 and dir=2: both rejected.
- house_hit and exit_valid in the same cycle → end_game=1, no exit_ack; room unchanged; stays in WIN for 1000 cycles.
- Run 60×61 frames in PLAY → seconds=61. Force 1100 s → seconds holds at 999.
- Reset asserted 2 frames into TRANS → IDLE, room (START_X,START_Y), rooms_entered=0, respawn never re-pulses.
